digital_tube_scan_driver: RTL
=============================

Name: digital_tube_scan_driver

Overview:
- Time-multiplexed scan driver for an 8-digit seven-segment tube.
- Takes a 32-bit hex value (8 nibbles) plus per-digit decimal-point and blank masks, and cycles one digit at a time.
- Produces the segment code `codeout` and the active-low digit select `seg` that the display selector forwards to the pins.
- New values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits (no tearing).

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is lit; legal range >= 2.
- DIGITS, 8: number of scanned digits; legal range 1..8. Digits >= DIGITS are never selected.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable; 0 blanks the tube and holds the scan position
- load  input  1  one-cycle strobe; captures data_in, dp_in and blank_in
- data_in  input  32  digit i = data_in[4i+3:4i], hex 0..F
- dp_in  input  8  bit i lights the decimal point of digit i
- blank_in  input  8  bit i forces digit i fully dark
- codeout  output  8  segment code, active-high: [7]=dp, [6:0]=g,f,e,d,c,b,a
- seg  output  8  digit select, active-low one-hot; 8'hFF means all digits off
- frame_done  output  1  one-cycle pulse when the scan wraps from the last digit back to digit 0
- pending  output  1  staged data is waiting for the next frame boundary

Behaviour:
- Reset is asynchronous on rst_n low; the clock is clk only. On reset:
  - codeout=8'h00, seg=8'hFF, frame_done=0, pending=0.
  - prescaler=0, digit index idx=0.
  - Active and staging registers (data, dp, blank) are all 0.
- Reset may assert mid-frame or mid-pending; all state is discarded, with no partial update.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while en=1.
  - `tick` is asserted when prescaler==SCAN_DIV-1; the prescaler then returns to 0.
- Digit index:
  - On tick, idx advances by 1.
  - When idx==DIGITS-1, idx wraps to 0 instead; this is the "frame boundary".
- frame_done is registered and high for exactly the one cycle following the boundary tick.
- Load handling, en=1:
  - load writes the staging register and sets pending=1.
  - A second load while pending overwrites staging; the last write wins.
  - At the frame boundary, staging is copied to active and pending clears.
  - If load coincides with the boundary tick, data_in/dp_in/blank_in go directly to active and pending=0.
- Load handling, en=0: load writes active directly; pending stays 0.
  - If pending=1 when en falls, staging is copied to active on the first en=0 cycle and pending clears.
- Output register, updated every cycle, based on the current idx and active registers:
  - en=0: codeout=8'h00, seg=8'hFF. Prescaler and idx are held at 0 and frame_done stays 0.
  - Active blank[idx]=1: codeout=8'h00, seg=8'hFF for that slot.
  - Otherwise: seg = ~(8'b1<<idx); codeout = {dp[idx], hex7(data[idx])}.
  - Outputs lag idx by exactly one clock.
- hex7 table (values are {g..a}):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- en rising from 0: scan restarts at digit 0 with a full SCAN_DIV dwell. The first lit output appears one cycle after en=1.
- Dwell per digit is exactly SCAN_DIV cycles; the frame period is SCAN_DIV*DIGITS cycles.
- With DIGITS=1, every tick is a frame boundary.

Test Plan:
- Reset with SCAN_DIV=4, DIGITS=8, en=1:
  - During reset: codeout=00, seg=FF.
  - First clock after release: codeout=3F, seg=FE.
  - seg then walks FE,FD,FB..7F, 4 cycles each.
  - frame_done pulses once every 32 cycles.
- Scan content: load data_in=32'h76543210, dp_in=8'h01, blank_in=0 while en=0, then set en=1.
  - Digit 0 shows codeout=BF.
  - Following digits show 06,5B,4F,66,6D,7D,07.
- Tearing: load 32'hFFFFFFFF at digit 3 mid-frame.
  - pending=1; digits 3..7 still show the old values.
  - After frame_done: every digit shows 71 and pending=0.
- Simultaneous events:
  - load on the boundary-tick cycle is applied to the very next digit 0, with pending staying 0.
  - Two loads inside one frame: only the second is displayed.
- Blank/en:
  - blank_in=8'h80: seg never equals 7F; slot 7 outputs FF/00 with unchanged timing.
  - en dropped mid-digit 5: next cycle outputs 00/FF. After en returns, scan resumes at digit 0 with a 4-cycle dwell.
- Reset mid-frame with pending=1: all outputs return to their reset values immediately. After release the display shows 3F on digit 0 and the staged data is lost.

Source files
------------

// File: rtl/digital_tube_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : digital_tube_scan_driver
//  Brief    : 8-digit seven-segment scan driver with frame-synchronous,
//             double-buffered update of data, decimal points and blanking.
//  Revision : 1.0  initial release
// ============================================================================
module digital_tube_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    output logic [7:0]  codeout,
    output logic [7:0]  seg,
    output logic        frame_done,
    output logic        pending
);

    localparam int             PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  C_LAST_CNT = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     C_LAST_IDX = 3'(DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   act_data_q, act_data_d, stg_data_q, stg_data_d;
    logic [7:0]    act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
    logic [7:0]    act_blank_q, act_blank_d, stg_blank_q, stg_blank_d;
    logic          pending_q, pending_d;
    logic [7:0]    codeout_q, codeout_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic          tick;
    logic          boundary;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        stg_data_d   = stg_data_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        codeout_d    = 8'h00;
        seg_d        = 8'hFF;
        tick         = 1'b0;
        boundary     = 1'b0;

        if (en) begin
            tick         = (presc_q == C_LAST_CNT);
            boundary     = tick && (idx_q == C_LAST_IDX);
            presc_d      = tick ? '0 : presc_q + PW'(1);
            frame_done_d = boundary;
            if (tick) begin
                idx_d = boundary ? 3'd0 : idx_q + 3'd1;
            end

            // Display reflects the index and active bank as they stand now.
            if (!act_blank_q[idx_q]) begin
                seg_d     = ~(8'h01 << idx_q);
                codeout_d = {act_dp_q[idx_q], hex7(act_data_q[{idx_q, 2'b00} +: 4])};
            end

            if (load && boundary) begin
                act_data_d  = data_in;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
                pending_d   = 1'b0;
            end else if (load) begin
                stg_data_d  = data_in;
                stg_dp_d    = dp_in;
                stg_blank_d = blank_in;
                pending_d   = 1'b1;
            end else if (boundary && pending_q) begin
                act_data_d  = stg_data_q;
                act_dp_d    = stg_dp_q;
                act_blank_d = stg_blank_q;
                pending_d   = 1'b0;
            end
        end else begin
            presc_d = '0;
            idx_d   = 3'd0;
            // Tube is dark, so tearing is impossible: apply immediately.
            if (load) begin
                act_data_d  = data_in;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
            end else if (pending_q) begin
                act_data_d  = stg_data_q;
                act_dp_d    = stg_dp_q;
                act_blank_d = stg_blank_q;
            end
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            act_data_q   <= 32'h0;
            act_dp_q     <= 8'h00;
            act_blank_q  <= 8'h00;
            stg_data_q   <= 32'h0;
            stg_dp_q     <= 8'h00;
            stg_blank_q  <= 8'h00;
            pending_q    <= 1'b0;
            codeout_q    <= 8'h00;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            stg_data_q   <= stg_data_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            pending_q    <= pending_d;
            codeout_q    <= codeout_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign codeout    = codeout_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
`default_nettype wire
